line_memory: RTL and testbench
==============================

# line_memory

Parametrised backing store for the data-cache refill and writeback path. It replaces the fixed 16 KiB / 32-byte-line model with configurable line width, depth and access latency. Requests are latched when accepted, byte-enabled partial-line writes are supported, and back-to-back requests can be issued. It sits below the L1 data cache controller and answers each request with exactly one ack pulse after a fixed number of cycles.

## Interface
Parameters:
- LINE_BYTES, 32, bytes per line; power of two, ≥4.
- DEPTH_BITS, 9, log2 of line count; the default gives 512 lines = 16 KiB.
- LATENCY, 10, cycles from accept edge to ack cycle; must be ≥2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; one clock, reset is asynchronous and active-low.
- addr_i  in  32  byte address; bits below log2(LINE_BYTES) are ignored.
- data_i  in  LINE_BYTES*8  write line.
- be_i  in  LINE_BYTES  byte enables; bit k covers data_i[8k+7:8k].
- enable_i  in  1  request valid.
- write_i  in  1  1 = write, 0 = read.
- busy_o  out  1  request in flight; high from the accept edge through the ack cycle.
- ack_o  out  1  single-cycle completion pulse.
- data_o  out  LINE_BYTES*8  completed line: read data, or the merged line after a write.
- err_o  out  1  address error, qualified by ack_o. Tied to 0 unless LINE_MEMORY_ERR_EN is defined.

## Operation
- States: IDLE and WAIT.
- Acceptance: a request is accepted at any edge where enable_i=1 and the block is either in IDLE or in the ack cycle.
- On accept: latch addr_i, data_i, be_i and write_i; set count to 1; go to WAIT. Inputs after the accept edge are ignored.
- WAIT: count increments every edge. ack_o = (state==WAIT) && (count==LATENCY-1+1), i.e. count==LATENCY.
- Ack-cycle edge:
  - With a new request pending, re-accept it (count←1, stay in WAIT).
  - Otherwise go to IDLE and set count←0.
- Index: index = addr[log2(LINE_BYTES)+DEPTH_BITS-1 : log2(LINE_BYTES)].
- Commit happens at the edge where count goes LATENCY-1 → LATENCY, the edge entering the ack cycle.
  - Read: data_o ← mem[index].
  - Write: for each byte k, mem[index] byte k ← data_i byte k if be_i[k], otherwise the old byte. data_o ← the merged line.
  - be_i = 0 on a write leaves memory unchanged and still acks.
- data_o holds its value until the next commit.
- Memory array contents are not reset.

## Timing
- Reset values: state IDLE, count 0, busy_o 0, ack_o 0, data_o 0, err_o 0.
- Accept at edge E0 → ack_o high in the cycle after edge E0+LATENCY-1; data_o and err_o are valid in that same cycle.
- Throughput: back-to-back requests give one ack every LATENCY cycles. If enable_i is idle in the ack cycle, the minimum spacing is LATENCY+1 cycles.
- enable_i high while busy_o=1 outside the ack cycle is ignored; the requester must hold it.
- Reset asserted mid-request: the request is dropped and no ack is issued. Memory is unchanged if reset lands before the commit edge.
- Read after write to the same index, issued back-to-back, returns the merged data.

## Configuration
- LINE_MEMORY_ERR_EN defined:
  - Address bits [31 : log2(LINE_BYTES)+DEPTH_BITS] are checked at commit.
  - If any of those bits is non-zero, the write is suppressed, data_o is forced to all-zero, and err_o=1 for the ack cycle.
  - err_o=0 in all other cycles.
- LINE_MEMORY_ERR_EN undefined: upper address bits are ignored (the address wraps modulo 2^(log2(LINE_BYTES)+DEPTH_BITS)), and err_o is constant 0.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles with enable_i=0 → no ack_o, busy_o=0.
- Full write then read, defaults:
  - Write addr 0x40, data = 256'h0123…ef pattern, be=all 1s → ack 9 cycles after accept, data_o = pattern.
  - Read addr 0x40 → same pattern.
- Partial write:
  - Preload line 0x80 with all 0xAA.
  - Write 0x80 with be=32'h0000_000F, data bytes 0x11 → read returns bytes 0–3 = 0x11, bytes 4–31 = 0xAA.
- Back-to-back: enable_i held high for 3 requests (W 0x100, R 0x100, R 0x120) → acks exactly 10 cycles apart; the second ack returns the written line.
- Reset mid-flight: accept write to 0x200, pull rst_i low 5 cycles later → no ack; a subsequent read of 0x200 returns the old contents.
- Address 0x0001_0000 with LATENCY=4:
  - LINE_MEMORY_ERR_EN defined → err_o=1 with ack, data_o=0, line 0 unchanged.
  - LINE_MEMORY_ERR_EN undefined → access aliases to line 0, err_o=0.

Source files
------------

// File: rtl/line_memory.sv
// line_memory: parametrised line-wide backing store with fixed-latency request/ack handshake
// Optional feature: define LINE_MEMORY_ERR_EN to flag and suppress accesses with non-zero
// address bits above the indexed range (err_o pulses with ack_o, data_o forced to zero).
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset
//   addr_i   - byte address, offset bits below log2(LINE_BYTES) ignored
//   data_i   - write line
//   be_i     - byte enables, bit k covers data_i[8k+7:8k]
//   enable_i - request valid
//   write_i  - 1 = write, 0 = read
//   busy_o   - request in flight, from accept edge through ack cycle
//   ack_o    - single-cycle completion pulse
//   data_o   - completed line (read data or merged write line), held until next commit
//   err_o    - address error, qualified by ack_o
module line_memory #(
  parameter int LINE_BYTES = 32,
  parameter int DEPTH_BITS = 9,
  parameter int LATENCY    = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             addr_i,
  input  logic [LINE_BYTES*8-1:0] data_i,
  input  logic [LINE_BYTES-1:0]   be_i,
  input  logic                    enable_i,
  input  logic                    write_i,
  output logic                    busy_o,
  output logic                    ack_o,
  output logic [LINE_BYTES*8-1:0] data_o,
  output logic                    err_o
);
  localparam int OFF = $clog2(LINE_BYTES);
  localparam int W   = LINE_BYTES * 8;
  localparam int CW  = $clog2(LATENCY + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                  r_state;
  logic [CW-1:0]           r_count;
  logic [DEPTH_BITS-1:0]   r_idx;
  logic                    r_hi;
  logic [W-1:0]            r_data;
  logic [LINE_BYTES-1:0]   r_be;
  logic                    r_write;
  logic [W-1:0]            r_q;
  logic                    r_err;
  logic [W-1:0]            r_mem [0:(1<<DEPTH_BITS)-1];
  logic                    w_ack;
  logic                    w_commit;
  logic                    w_accept;
  logic                    w_hi;
  logic                    w_unused;
  logic [W-1:0]            w_old;
  logic [W-1:0]            w_merged;
  logic [W-1:0]            w_line;
`ifdef LINE_MEMORY_ERR_EN
  assign w_hi     = |addr_i[31:OFF+DEPTH_BITS];
  assign w_unused = ^addr_i[OFF-1:0];
`else
  // Upper bits simply alias: the address wraps within the array.
  assign w_hi     = 1'b0;
  assign w_unused = ^{addr_i[31:OFF+DEPTH_BITS], addr_i[OFF-1:0]};
`endif
  assign w_ack    = (r_state == WAIT) && (r_count == CW'(LATENCY));
  // The edge that moves count into LATENCY is the one that updates memory and data_o.
  assign w_commit = (r_state == WAIT) && (r_count == CW'(LATENCY - 1));
  // The ack cycle doubles as an accept slot so back-to-back requests lose no cycle.
  assign w_accept = enable_i && ((r_state == IDLE) || w_ack);
  assign w_old    = r_mem[r_idx];
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_merge
    assign w_merged[8*b +: 8] = r_be[b] ? r_data[8*b +: 8] : w_old[8*b +: 8];
  end
  assign w_line = r_write ? w_merged : w_old;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_hi    <= 1'b0;
      r_data  <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
      r_q     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_q   <= r_hi ? '0 : w_line;
        r_err <= r_hi;
      end
      if (w_accept) begin
        r_state <= WAIT;
        r_count <= CW'(1);
        r_idx   <= addr_i[OFF +: DEPTH_BITS];
        r_hi    <= w_hi;
        r_data  <= data_i;
        r_be    <= be_i;
        r_write <= write_i;
      end else if (w_ack) begin
        r_state <= IDLE;
        r_count <= '0;
      end else if (r_state == WAIT) begin
        r_count <= r_count + 1'b1;
      end
    end
  end
  // Array is intentionally left out of reset; a reset before the commit edge leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (w_commit && r_write && !r_hi) r_mem[r_idx] <= w_merged;
  end
  assign busy_o = (r_state == WAIT);
  assign ack_o  = w_ack;
  assign data_o = r_q;
  assign err_o  = w_ack && r_err;
endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: directed table-driven bench for line_memory (LATENCY 10 and LATENCY 4 instances)
module tb_line_memory;
  localparam int LB = 32;
  localparam int W  = LB * 8;
`ifdef LINE_MEMORY_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [LB-1:0] ALL  = '1;
  localparam logic [W-1:0]  P    = {4{64'h0123456789abcdef}};
  localparam logic [W-1:0]  AA   = {32{8'hAA}};
  localparam logic [W-1:0]  PART = {{28{8'hAA}}, {4{8'h11}}};
  localparam logic [W-1:0]  P120 = {8{32'hcafe0120}};
  localparam logic [W-1:0]  P200 = {8{32'h00200200}};
  localparam logic [W-1:0]  Q    = {8{32'hbeef0100}};
  localparam logic [W-1:0]  L0   = {8{32'h5a5a0f0f}};
  localparam logic [W-1:0]  Z    = {8{32'hdeadbeef}};
  typedef struct {
    bit            sel;
    bit            wr;
    logic [31:0]   a;
    logic [W-1:0]  d;
    logic [LB-1:0] be;
    logic [W-1:0]  exp;
    bit            ee;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [31:0]   addr;
  logic [W-1:0]  data;
  logic [LB-1:0] be;
  logic          wr, en_a, en_b;
  logic          busy_a, ack_a, err_a, busy_b, ack_b, err_b;
  logic [W-1:0]  q_a, q_b;
  int total = 0;
  int bad = 0;
  line_memory u_a (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data), .be_i(be),
    .enable_i(en_a), .write_i(wr), .busy_o(busy_a), .ack_o(ack_a), .data_o(q_a), .err_o(err_a)
  );
  line_memory #(.LATENCY(4)) u_b (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data), .be_i(be),
    .enable_i(en_b), .write_i(wr), .busy_o(busy_b), .ack_o(ack_b), .data_o(q_b), .err_o(err_b)
  );
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic req(input bit sel, input bit w, input logic [31:0] a, input logic [W-1:0] d,
                     input logic [LB-1:0] b, output logic [W-1:0] q, output logic e, output int lat);
    @(negedge clk);
    addr = a; data = d; be = b; wr = w; en_a = !sel; en_b = sel;
    @(posedge clk);
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; lat = 1;
    while (!(sel ? ack_b : ack_a) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = sel ? q_b : q_a;
    e = sel ? err_b : err_a;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t          tv[14];
    logic [W-1:0]  q;
    logic          e;
    int            lat, n, acks;
    longint        tack[3];
    logic [31:0]   ba[3];
    bit            bw[3];
    logic [W-1:0]  bx[3];
    tv[0]  = '{0, 1, 32'h40,    P,             ALL,     P,                   0};
    tv[1]  = '{0, 0, 32'h40,    '0,            '0,      P,                   0};
    tv[2]  = '{0, 0, 32'h5F,    '0,            '0,      P,                   0};
    tv[3]  = '{0, 1, 32'h80,    AA,            ALL,     AA,                  0};
    tv[4]  = '{0, 1, 32'h80,    {32{8'h11}},   32'hF,   PART,                0};
    tv[5]  = '{0, 0, 32'h80,    '0,            '0,      PART,                0};
    tv[6]  = '{0, 1, 32'h80,    {32{8'h77}},   '0,      PART,                0};
    tv[7]  = '{0, 0, 32'h80,    '0,            '0,      PART,                0};
    tv[8]  = '{0, 1, 32'h120,   P120,          ALL,     P120,                0};
    tv[9]  = '{0, 1, 32'h200,   P200,          ALL,     P200,                0};
    tv[10] = '{1, 1, 32'h0,     L0,            ALL,     L0,                  0};
    tv[11] = '{1, 1, 32'h10000, Z,             ALL,     ERR_EN ? '0 : Z,     ERR_EN};
    tv[12] = '{1, 0, 32'h0,     '0,            '0,      ERR_EN ? L0 : Z,     0};
    tv[13] = '{1, 0, 32'h10000, '0,            '0,      ERR_EN ? '0 : Z,     ERR_EN};
    en_a = 0; en_b = 0; wr = 0; addr = '0; data = '0; be = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_ack_err", {W'(busy_a), W'(ack_a), W'(err_a)}, '0);
    check("rst_data_a", q_a, '0);
    check("rst_data_b", q_b, '0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), W'({busy_a, ack_a, err_a, busy_b, ack_b, err_b}), '0);
    end
    check("idle_data_a", q_a, '0);
    for (int i = 0; i < 14; i++) begin
      req(tv[i].sel, tv[i].wr, tv[i].a, tv[i].d, tv[i].be, q, e, lat);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(tv[i].sel ? 4 : 10));
      check($sformatf("vec%0d_data", i), q, tv[i].exp);
      check($sformatf("vec%0d_err", i), W'(e), W'(tv[i].ee));
    end
    ba = '{32'h100, 32'h100, 32'h120};
    bw = '{1'b1, 1'b0, 1'b0};
    bx = '{Q, Q, P120};
    @(negedge clk);
    addr = ba[0]; data = Q; be = ALL; wr = 1'b1; en_a = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        addr = ba[i+1]; wr = bw[i+1];
      end else en_a = 1'b0;
      n = 1;
      while (!ack_a && n < 40) begin
        @(negedge clk);
        n++;
      end
      tack[i] = $time;
      check($sformatf("b2b%0d_latency", i), W'(n), W'(10));
      check($sformatf("b2b%0d_data", i), q_a, bx[i]);
      if (i > 0) check($sformatf("b2b%0d_spacing", i), W'(tack[i] - tack[i-1]), W'(100));
      @(posedge clk);
    end
    @(negedge clk);
    check("b2b_single_pulse", W'({ack_a, busy_a}), '0);
    check("b2b_data_hold", q_a, P120);
    @(negedge clk);
    addr = 32'h200; data = ~P200; be = ALL; wr = 1'b1; en_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_outputs", W'({busy_a, ack_a, err_a}), '0);
    check("midrst_data", q_a, '0);
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack_a) acks++;
    end
    check("midrst_no_ack", W'(acks), '0);
    req(0, 0, 32'h200, '0, '0, q, e, lat);
    check("midrst_read_latency", W'(lat), W'(10));
    check("midrst_read_old", q, P200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
